if_fetch_stage: RTL

- Instruction-fetch stage of the 5-stage RV32I pipeline.
- Owns the PC register and the next-PC select. Drives a request/grant/response instruction-memory port and the IF/ID pipeline register.
- Consumes the ID-stage branch resolver outputs (pc_sel, flush, target) and the hazard unit's stall. Feeds ID with a {valid, pc, inst} triple.

---
 rtl/if_pkg.sv | 26 ++
 rtl/if_fetch_buf.sv | 57 +++++
 rtl/if_fetch_stage.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Package  : if_pkg
// Brief    : Shared types and constants for the RV32I instruction-fetch stage.
// Revision : 1.0
// ============================================================================
package if_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FULL = 2'd3
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_buf
// Brief    : One-entry {pc, inst} holding register for responses that arrive
//            while IF/ID is stalled.
// Revision : 1.0
// ============================================================================
module if_fetch_buf
  import if_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] inst_i,
  output logic            full_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] inst_o
);

  logic            full_q, full_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;

  always_comb begin
    full_d = full_q;
    pc_d   = pc_q;
    inst_d = inst_q;
    if (clear_i) begin
      full_d = 1'b0;
    end
    if (load_i) begin
      full_d = 1'b1;
      pc_d   = pc_i;
      inst_d = inst_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      pc_q   <= '0;
      inst_q <= NOP_INST;
    end else begin
      full_q <= full_d;
      pc_q   <= pc_d;
      inst_q <= inst_d;
    end
  end

  assign full_o = full_q;
  assign pc_o   = pc_q;
  assign inst_o = inst_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Brief    : RV32I fetch stage: PC, single-outstanding imem req/gnt/rvalid
//            port and the IF/ID pipeline register.
// Revision : 1.0
// ============================================================================
module if_fetch_stage #(
  parameter logic [if_pkg::XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [if_pkg::XLEN-1:0] NOP_INST = if_pkg::NOP_INST
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    pc_sel,
  input  logic                    flush,
  input  logic [if_pkg::XLEN-1:0] target,
  output logic                    imem_req,
  output logic [if_pkg::XLEN-1:0] imem_addr,
  input  logic                    imem_gnt,
  input  logic                    imem_rvalid,
  input  logic [if_pkg::XLEN-1:0] imem_rdata,
  output logic                    ifid_valid,
  output logic [if_pkg::XLEN-1:0] ifid_pc,
  output logic [if_pkg::XLEN-1:0] ifid_inst
);

  import if_pkg::*;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            stale_q, stale_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [XLEN-1:0] ifid_inst_q, ifid_inst_d;

  logic            rsp_live;
  logic            buf_load;
  logic            buf_clear;
  logic            buf_full;
  logic [XLEN-1:0] buf_pc;
  logic [XLEN-1:0] buf_inst;

  // Responses only count while a request is in flight and not superseded.
  assign rsp_live  = (state_q == S_WAIT) && imem_rvalid && !stale_q;
  assign buf_load  = rsp_live && stall && !flush;
  assign buf_clear = buf_full && (flush || pc_sel || !stall);

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    stale_d    = stale_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_gnt) begin
          fetch_pc_d = pc_q;
          pc_d       = pc_q + PC_STEP;
          stale_d    = pc_sel;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          stale_d = 1'b0;
          state_d = (!stale_q && stall && !flush) ? S_FULL : S_REQ;
        end else if (pc_sel) begin
          stale_d = 1'b1;
        end
      end
      S_FULL: begin
        if (buf_clear) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pc_sel) begin
      pc_d = word_align(target);
    end
  end

  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_inst_d  = ifid_inst_q;
    if (flush) begin
      ifid_valid_d = 1'b0;
      ifid_inst_d  = NOP_INST;
    end else if (!stall) begin
      if (buf_full) begin
        ifid_valid_d = 1'b1;
        ifid_pc_d    = buf_pc;
        ifid_inst_d  = buf_inst;
      end else if (rsp_live) begin
        ifid_valid_d = 1'b1;
        ifid_pc_d    = fetch_pc_q;
        ifid_inst_d  = imem_rdata;
      end else begin
        ifid_valid_d = 1'b0;
        ifid_inst_d  = NOP_INST;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= word_align(RESET_PC);
      fetch_pc_q   <= '0;
      stale_q      <= 1'b0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_inst_q  <= NOP_INST;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_pc_q   <= fetch_pc_d;
      stale_q      <= stale_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_inst_q  <= ifid_inst_d;
    end
  end

  if_fetch_buf u_fetch_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .pc_i    (fetch_pc_q),
    .inst_i  (imem_rdata),
    .full_o  (buf_full),
    .pc_o    (buf_pc),
    .inst_o  (buf_inst)
  );

  assign ifid_valid = ifid_valid_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_inst  = ifid_inst_q;

endmodule
`default_nettype wire
